// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back logic for the five-stage RV32I core.
// Drives the register file write port and tracks instruction retirement.
module wb_stage #(
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] mem_dmem_rd,
    input  logic [4:0]  mem_rd,
    input  logic        mem_rf_we,
    input  logic [1:0]  mem_wb_sel,
    input  logic [2:0]  mem_ld_type,
    output logic [4:0]  rf_wa,
    output logic        rf_we,
    output logic [31:0] rf_wd,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic        commit,
    output logic [31:0] commit_cnt
);

    logic        valid_r;
    logic        new_r;
    logic [31:0] pc_r;
    logic [31:0] alu_res_r;
    logic [31:0] dmem_rd_r;
    logic [4:0]  rd_r;
    logic        rf_we_fld_r;
    logic [1:0]  wb_sel_r;
    logic [2:0]  ld_type_r;
    logic [31:0] commit_cnt_r;

    logic        commit_s;
    logic [31:0] ld_data_s;
    logic [31:0] wd_s;

    // Byte/halfword extraction from the aligned memory word; unknown funct3 acts as LW.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [2:0]  funct3
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (off)
            2'b00:   byte_v = word[7:0];
            2'b01:   byte_v = word[15:8];
            2'b10:   byte_v = word[23:16];
            2'b11:   byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b100:  res_v = {24'd0, byte_v};
            3'b101:  res_v = {16'd0, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    // WB pipeline register; new_r marks the first cycle an instruction sits here.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_r     <= 1'b0;
            new_r       <= 1'b0;
            pc_r        <= RST_PC;
            alu_res_r   <= 32'd0;
            dmem_rd_r   <= 32'd0;
            rd_r        <= 5'd0;
            rf_we_fld_r <= 1'b0;
            wb_sel_r    <= 2'b00;
            ld_type_r   <= 3'b000;
        end else if (flush) begin
            valid_r <= 1'b0;
            new_r   <= 1'b0;
            pc_r    <= RST_PC;
        end else if (en) begin
            valid_r     <= mem_valid;
            new_r       <= mem_valid;
            pc_r        <= mem_pc;
            alu_res_r   <= mem_alu_res;
            dmem_rd_r   <= mem_dmem_rd;
            rd_r        <= mem_rd;
            rf_we_fld_r <= mem_rf_we;
            wb_sel_r    <= mem_wb_sel;
            ld_type_r   <= mem_ld_type;
        end else begin
            new_r <= 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            commit_cnt_r <= 32'd0;
        end else if (commit_s) begin
            commit_cnt_r <= commit_cnt_r + 32'd1;
        end else begin
            commit_cnt_r <= commit_cnt_r;
        end
    end

    // Commit detection and write-back source selection.
    always_comb begin
        commit_s  = valid_r & new_r;
        ld_data_s = load_extract(dmem_rd_r, alu_res_r[1:0], ld_type_r);
        case (wb_sel_r)
            2'b00:   wd_s = alu_res_r;
            2'b01:   wd_s = ld_data_s;
            2'b10:   wd_s = pc_r + 32'd4;
            2'b11:   wd_s = 32'd0;
            default: wd_s = 32'd0;
        endcase
    end

    assign rf_wa      = rd_r;
    assign rf_we      = commit_s & rf_we_fld_r & (rd_r != 5'd0);
    assign rf_wd      = wd_s;
    assign wb_valid   = valid_r;
    assign wb_pc      = pc_r;
    assign commit     = commit_s;
    assign commit_cnt = commit_cnt_r;

endmodule
